// File: rtl/adc_multi_channel_sequencer.sv
// XADC DRP multi-channel sequencer: sweeps NUM_CH aux channels per EOC,
// averages 2^AVG_LOG2 sweeps and streams channel-tagged samples.
module adc_multi_channel_sequencer #(
  parameter int unsigned NUM_CH       = 2,
  parameter logic [6:0]  CH_ADDR_BASE = 7'h10,
  parameter int unsigned ADC_BITS     = 12,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned AVG_LOG2     = 0,
  parameter bit          SIGNED_MODE  = 1'b1,
  parameter int unsigned DRDY_TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             eoc_in,
  output logic [6:0]       drp_daddr,
  output logic             drp_den,
  input  logic [15:0]      drp_do,
  input  logic             drp_drdy,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             timeout_err,
  output logic [15:0]      overrun_cnt
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
  localparam int unsigned SW_W  = AVG_LOG2 + 1;
  localparam int unsigned TO_W  = $clog2(DRDY_TIMEOUT + 1);

  localparam logic [SW_W-1:0] SWEEPS  = SW_W'(1 << AVG_LOG2);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, ACC, EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d, nxt_ch;
  logic [SW_W-1:0]     sweep_q, sweep_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
  logic [ADC_BITS-1:0] raw_q, raw_d;
  logic [ACC_W-1:0]    acc_q [NUM_CH];
  logic [ACC_W-1:0]    acc_d [NUM_CH];
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [2:0]          out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                terr_q, terr_d;
  logic [15:0]         ovr_q, ovr_d;

  function automatic logic [OUT_W-1:0] fmt(
    input logic [ACC_W-1:0] a
  );
    logic [ADC_BITS-1:0] avg;
    avg = ADC_BITS'(a >> AVG_LOG2);
    if (SIGNED_MODE) avg[ADC_BITS-1] = ~avg[ADC_BITS-1];
    return OUT_W'(avg) << (OUT_W - ADC_BITS);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      sweep_q     <= '0;
      tmo_q       <= '0;
      raw_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      terr_q      <= 1'b0;
      ovr_q       <= '0;
      for (int i = 0; i < NUM_CH; i++)
        acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sweep_q     <= sweep_d;
      tmo_q       <= tmo_d;
      raw_q       <= raw_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      terr_q      <= terr_d;
      ovr_q       <= ovr_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    nxt_ch      = ch_q + 1'b1;
    sweep_d     = sweep_q;
    tmo_d       = tmo_q;
    raw_d       = raw_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    terr_d      = terr_q;
    ovr_d       = ovr_q;

    if (eoc_in && state_q != IDLE && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (eoc_in) begin
          ch_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Data wins over a timeout landing on the same cycle.
        if (drp_drdy) begin
          raw_d   = drp_do[15 -: ADC_BITS];
          state_d = ACC;
        end else if (tmo_q == TO_LAST) begin
          raw_d   = '0;
          terr_d  = 1'b1;
          state_d = ACC;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ACC: begin
        acc_d[ch_q] = acc_q[ch_q] + ACC_W'(raw_q);
        if (ch_q != LAST_CH) begin
          ch_d    = nxt_ch;
          state_d = REQ;
        end else begin
          sweep_d = sweep_q + 1'b1;
          ch_d    = '0;
          if (sweep_q + 1'b1 == SWEEPS) state_d = EMIT;
          else state_d = IDLE;
        end
      end
      EMIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = fmt(acc_q[ch_q]);
          out_ch_d    = 3'(ch_q);
        end else if (out_ready) begin
          acc_d[ch_q] = '0;
          if (ch_q == LAST_CH) begin
            out_valid_d = 1'b0;
            sweep_d     = '0;
            state_d     = IDLE;
          end else begin
            ch_d       = nxt_ch;
            out_data_d = fmt(acc_q[nxt_ch]);
            out_ch_d   = 3'(nxt_ch);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drp_den     = (state_q == REQ);
  assign drp_daddr   = CH_ADDR_BASE + 7'(ch_q);
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign out_valid   = out_valid_q;
  assign timeout_err = terr_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_adc_multi_channel_sequencer.sv
// Directed bench: dual-channel signed instance (a) and
// single-channel 4-sweep averaging unsigned instance (b).
module tb_adc_multi_channel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        eoc_a, den_a, drdy_a, valid_a, ready_a, terr_a;
  logic [6:0]  addr_a;
  logic [15:0] do_a, data_a, ovr_a;
  logic [2:0]  ch_a;
  logic        eoc_b, den_b, drdy_b, valid_b, ready_b, terr_b;
  logic [6:0]  addr_b;
  logic [15:0] do_b, data_b, ovr_b;
  logic [2:0]  ch_b;

  int checks = 0;
  int errors = 0;

  adc_multi_channel_sequencer #(
    .NUM_CH(2), .AVG_LOG2(0), .SIGNED_MODE(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .eoc_in(eoc_a),
    .drp_daddr(addr_a), .drp_den(den_a),
    .drp_do(do_a), .drp_drdy(drdy_a),
    .out_data(data_a), .out_ch(ch_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .timeout_err(terr_a), .overrun_cnt(ovr_a)
  );

  adc_multi_channel_sequencer #(
    .NUM_CH(1), .AVG_LOG2(2), .SIGNED_MODE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .eoc_in(eoc_b),
    .drp_daddr(addr_b), .drp_den(den_b),
    .drp_do(do_b), .drp_drdy(drdy_b),
    .out_data(data_b), .out_ch(ch_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .timeout_err(terr_b), .overrun_cnt(ovr_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_den(input bit b, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (b ? den_b : den_a) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_den"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input bit b, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (b ? valid_b : valid_a) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(ok), 32'd1);
  endtask

  task automatic get_out_a(input logic [15:0] ed,
                           input logic [2:0] ec,
                           input string tag);
    wait_valid(1'b0, tag);
    chk({tag, "_data"}, 32'(data_a), 32'(ed));
    chk({tag, "_ch"}, 32'(ch_a), 32'(ec));
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
  endtask

  task automatic sweep_a(input logic [15:0] d0,
                         input logic [15:0] d1,
                         input bit r1,
                         input string tag);
    eoc_a = 1'b1;
    @(negedge clk);
    eoc_a = 1'b0;
    wait_den(1'b0, {tag, "0"});
    chk({tag, "_addr0"}, 32'(addr_a), 32'h10);
    @(negedge clk);
    chk({tag, "_den0_pulse"}, 32'(den_a), 32'd0);
    drdy_a = 1'b1;
    do_a   = d0;
    @(negedge clk);
    drdy_a = 1'b0;
    wait_den(1'b0, {tag, "1"});
    chk({tag, "_addr1"}, 32'(addr_a), 32'h11);
    @(negedge clk);
    chk({tag, "_den1_pulse"}, 32'(den_a), 32'd0);
    if (r1) begin
      drdy_a = 1'b1;
      do_a   = d1;
      @(negedge clk);
      drdy_a = 1'b0;
    end
  endtask

  task automatic sweep_b(input logic [15:0] d, input string tag);
    eoc_b = 1'b1;
    @(negedge clk);
    eoc_b = 1'b0;
    wait_den(1'b1, tag);
    chk({tag, "_addr"}, 32'(addr_b), 32'h10);
    @(negedge clk);
    drdy_b = 1'b1;
    do_b   = d;
    @(negedge clk);
    drdy_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {eoc_a, drdy_a, ready_a, eoc_b, drdy_b, ready_b} = '0;
    do_a = '0;
    do_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_den", 32'(den_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'h10);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_ch", 32'(ch_a), 32'd0);
    chk("rst_terr", 32'(terr_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    sweep_a(16'hFFF0, 16'h0000, 1'b1, "basic");
    get_out_a(16'h7FF0, 3'd0, "basic_c0");
    get_out_a(16'h8000, 3'd1, "basic_c1");
    chk("basic_done", 32'(valid_a), 32'd0);
    chk("basic_terr", 32'(terr_a), 32'd0);

    sweep_b(16'h1000, "avg1");
    repeat (6) @(negedge clk);
    chk("avg1_novalid", 32'(valid_b), 32'd0);
    sweep_b(16'h1020, "avg2");
    repeat (6) @(negedge clk);
    chk("avg2_novalid", 32'(valid_b), 32'd0);
    sweep_b(16'h1040, "avg3");
    repeat (6) @(negedge clk);
    chk("avg3_novalid", 32'(valid_b), 32'd0);
    sweep_b(16'h1060, "avg4");
    wait_valid(1'b1, "avg4");
    chk("avg4_data", 32'(data_b), 32'h1030);
    chk("avg4_ch", 32'(ch_b), 32'd0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("avg4_single", 32'(valid_b), 32'd0);

    sweep_a(16'h1230, 16'h0000, 1'b0, "tmo");
    get_out_a(16'h9230, 3'd0, "tmo_c0");
    get_out_a(16'h8000, 3'd1, "tmo_c1");
    chk("tmo_terr", 32'(terr_a), 32'd1);

    sweep_a(16'hABC0, 16'h5550, 1'b1, "hold");
    wait_valid(1'b0, "hold");
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", 32'(valid_a), 32'd1);
      chk("hold_data", 32'(data_a), 32'h2BC0);
      chk("hold_ch", 32'(ch_a), 32'd0);
      chk("hold_noden", 32'(den_a), 32'd0);
      eoc_a = (i == 3 || i == 8 || i == 13);
      @(negedge clk);
    end
    eoc_a = 1'b0;
    chk("hold_ovr", 32'(ovr_a), 32'd3);
    get_out_a(16'h2BC0, 3'd0, "hold_c0");
    get_out_a(16'hD550, 3'd1, "hold_c1");
    chk("hold_terr_sticky", 32'(terr_a), 32'd1);

    eoc_a = 1'b1;
    @(negedge clk);
    eoc_a = 1'b0;
    wait_den(1'b0, "rw0");
    @(negedge clk);
    drdy_a = 1'b1;
    do_a   = 16'h7FF0;
    @(negedge clk);
    drdy_a = 1'b0;
    wait_den(1'b0, "rw1");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    drdy_a = 1'b1;
    do_a   = 16'hFFF0;
    @(negedge clk);
    drdy_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("rw_den", 32'(den_a), 32'd0);
    chk("rw_addr", 32'(addr_a), 32'h10);
    chk("rw_valid", 32'(valid_a), 32'd0);
    chk("rw_data", 32'(data_a), 32'd0);
    chk("rw_ch", 32'(ch_a), 32'd0);
    chk("rw_terr", 32'(terr_a), 32'd0);
    chk("rw_ovr", 32'(ovr_a), 32'd0);
    sweep_a(16'h0010, 16'h0020, 1'b1, "clean");
    get_out_a(16'h8010, 3'd0, "clean_c0");
    get_out_a(16'h8020, 3'd1, "clean_c1");

    sweep_a(16'h0000, 16'hFFF0, 1'b1, "sat");
    wait_valid(1'b0, "sat");
    eoc_a = 1'b1;
    repeat (65540) @(negedge clk);
    eoc_a = 1'b0;
    chk("sat_ovr", 32'(ovr_a), 32'hFFFF);
    chk("sat_valid", 32'(valid_a), 32'd1);
    get_out_a(16'h8000, 3'd0, "sat_c0");
    get_out_a(16'h7FF0, 3'd1, "sat_c1");
    chk("sat_ovr_hold", 32'(ovr_a), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
